// File: rtl/bcd_time_keeper_pkg.sv
// Shared encodings and digit limits for the BCD time keeper.
package bcd_time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } set_state_e;

    localparam int unsigned UNITS_MAX           = 9;
    localparam int unsigned SEC_TENS_MAX        = 5;
    localparam int unsigned MIN_TENS_MAX        = 5;
    localparam int unsigned HOUR_TENS_MAX       = 2;
    localparam int unsigned HOUR_UNITS_MAX_AT_2 = 3;

endpackage

// File: rtl/bcd_time_keeper_if.sv
// Button inputs and time/status outputs of the time keeper, grouped as a bundle.
interface bcd_time_keeper_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] sec0;
    logic [3:0] sec1;
    logic [3:0] min0;
    logic [3:0] min1;
    logic [3:0] hour0;
    logic [3:0] hour1;
    logic [1:0] set_state;
    logic       tick_1hz;

    modport master (
        output btn_mode, btn_inc,
        input  sec0, sec1, min0, min1, hour0, hour1, set_state, tick_1hz
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec0, sec1, min0, min1, hour0, hour1, set_state, tick_1hz
    );
endinterface

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping TENS_MAX:UNITS_MAX_AT_TOP -> 00, with carry and clear.
module bcd_pair_counter
    import bcd_time_keeper_pkg::*;
#(
    parameter int unsigned TENS_MAX         = 5,
    parameter int unsigned UNITS_MAX_AT_TOP = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       carry_out
);

    logic [3:0] units_q, units_d;
    logic [3:0] tens_q, tens_d;
    logic       at_top;

    assign at_top    = (tens_q == 4'(TENS_MAX)) && (units_q == 4'(UNITS_MAX_AT_TOP));
    assign carry_out = inc && at_top && !clr;
    assign units     = units_q;
    assign tens      = tens_q;

    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (clr) begin
            units_d = '0;
            tens_d  = '0;
        end else if (inc) begin
            if (at_top) begin
                units_d = '0;
                tens_d  = '0;
            end else if (units_q == 4'(UNITS_MAX)) begin
                units_d = '0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            units_q <= '0;
            tens_q  <= '0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD clock with 1 s prescaler and two-button hour/minute setting.
module bcd_time_keeper
    import bcd_time_keeper_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] hour0,
    output logic [3:0] hour1,
    output logic [1:0] set_state,
    output logic       tick_1hz
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    set_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic              mode_hist_q, inc_hist_q;

    logic mode_edge, inc_edge, edit_inc, in_run, wrap, advance;
    logic sec_inc, sec_clr, sec_carry;
    logic min_inc, min_carry;
    logic hour_inc, hour_carry;

    assign mode_edge = btn_mode && !mode_hist_q;
    assign inc_edge  = btn_inc && !inc_hist_q;
    // A mode edge always wins: it discards a same-cycle inc edge and a same-cycle tick.
    assign edit_inc  = inc_edge && !mode_edge;
    assign in_run    = (state_q == ST_RUN);
    assign wrap      = in_run && (cnt_q == CNT_W'(TICK_DIV - 1));
    assign advance   = wrap && !mode_edge;

    assign sec_inc  = advance;
    assign sec_clr  = in_run && mode_edge;
    assign min_inc  = (in_run && sec_carry) || ((state_q == ST_SET_MIN) && edit_inc);
    assign hour_inc = (in_run && min_carry) || ((state_q == ST_SET_HR) && edit_inc);
    assign tick_d   = advance;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_RUN: begin
                if (mode_edge)  state_d = ST_SET_HR;
                else if (!wrap) cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_SET_HR:  if (mode_edge) state_d = ST_SET_MIN;
            ST_SET_MIN: if (mode_edge) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            mode_hist_q <= 1'b0;
            inc_hist_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            mode_hist_q <= btn_mode;
            inc_hist_q  <= btn_inc;
        end
    end

    assign set_state = state_q;
    assign tick_1hz  = tick_q;

    bcd_pair_counter #(.TENS_MAX(SEC_TENS_MAX), .UNITS_MAX_AT_TOP(UNITS_MAX)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc), .clr(sec_clr),
        .units(sec0), .tens(sec1), .carry_out(sec_carry)
    );

    bcd_pair_counter #(.TENS_MAX(MIN_TENS_MAX), .UNITS_MAX_AT_TOP(UNITS_MAX)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
        .units(min0), .tens(min1), .carry_out(min_carry)
    );

    // Hour carry is the day wrap; nothing above hours consumes it.
    bcd_pair_counter #(.TENS_MAX(HOUR_TENS_MAX), .UNITS_MAX_AT_TOP(HOUR_UNITS_MAX_AT_2)) u_hour (
        .clk(clk), .rst(rst), .inc(hour_inc), .clr(1'b0),
        .units(hour0), .tens(hour1), .carry_out(hour_carry)
    );

    logic unused_hour_carry;
    assign unused_hour_carry = hour_carry;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Scoreboard bench: time-of-day model in plain seconds, monitor compares every cycle.
module tb_bcd_time_keeper;

    localparam int unsigned DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_time_keeper_if bus ();

    bcd_time_keeper #(.TICK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (bus.btn_mode),
        .btn_inc  (bus.btn_inc),
        .sec0     (bus.sec0),
        .sec1     (bus.sec1),
        .min0     (bus.min0),
        .min1     (bus.min1),
        .hour0    (bus.hour0),
        .hour1    (bus.hour1),
        .set_state(bus.set_state),
        .tick_1hz (bus.tick_1hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned tpush;
        int              secs;
        int              st;
        bit              tk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time as seconds-of-day, mode 0/1/2, prescaler phase.
    int m_t  = 0;
    int m_st = 0;
    int m_pc = 0;
    bit m_tk = 0;
    bit m_mh = 0;
    bit m_ih = 0;

    function automatic logic [23:0] bcd_of(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step(input bit bm, input bit bi, input bit r);
        bit me, ie;
        int h, m, s;
        if (r) begin
            m_t = 0; m_st = 0; m_pc = 0; m_tk = 0; m_mh = 0; m_ih = 0;
            return;
        end
        me = bm && !m_mh;
        ie = bi && !m_ih;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        m_tk = 0;
        case (m_st)
            0: begin
                if (me) begin
                    m_st = 1; m_t = m_t - s; m_pc = 0;
                end else if (m_pc == DIV - 1) begin
                    m_pc = 0; m_t = (m_t + 1) % 86400; m_tk = 1;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
            1: begin
                m_pc = 0;
                if (me) m_st = 2;
                else if (ie) m_t = ((h + 1) % 24) * 3600 + m * 60 + s;
            end
            default: begin
                m_pc = 0;
                if (me) m_st = 0;
                else if (ie) m_t = h * 3600 + ((m + 1) % 60) * 60 + s;
            end
        endcase
        m_mh = bm;
        m_ih = bi;
    endtask

    task automatic cyc(input bit bm, input bit bi, input bit r);
        exp_t e;
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        rst          = r;
        model_step(bm, bi, r);
        e.tpush = $time;
        e.secs  = m_t;
        e.st    = m_st;
        e.tk    = m_tk;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_mode();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: an entry applies to the first edge after it was pushed.
    exp_t        me_e;
    logic [23:0] got_t;
    always @(posedge clk) begin
        #2;
        if (q.size() > 0 && q[0].tpush < $time - 2) begin
            me_e  = q.pop_front();
            got_t = {bus.hour1, bus.hour0, bus.min1, bus.min0, bus.sec1, bus.sec0};
            checks++;
            if (got_t !== bcd_of(me_e.secs)) begin
                errors++;
                $display("FAIL time @%0t: got %h required %h", $time, got_t, bcd_of(me_e.secs));
            end
            checks++;
            if (bus.set_state !== 2'(me_e.st)) begin
                errors++;
                $display("FAIL set_state @%0t: got %b required %b", $time, bus.set_state, 2'(me_e.st));
            end
            checks++;
            if (bus.tick_1hz !== me_e.tk) begin
                errors++;
                $display("FAIL tick_1hz @%0t: got %b required %b", $time, bus.tick_1hz, me_e.tk);
            end
        end
    end

    initial begin
        bit rb, ri;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then one simulated minute.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        idle(DIV * 60);

        // Edit hours from a running 00:01:37.
        idle(DIV * 37);
        press_mode();
        for (int i = 0; i < 25; i++) press_inc();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Minutes up to 59, then one more wraps to 00 without touching hours.
        press_mode();
        while ((m_t / 60) % 60 != 59) press_inc();
        press_inc();
        press_mode();
        idle(3 * DIV);

        // Preload 23:59:00, run to 23:59:58, then across midnight.
        press_mode();
        while (m_t / 3600 != 23) press_inc();
        press_mode();
        while ((m_t / 60) % 60 != 59) press_inc();
        press_mode();
        idle(DIV * 58);
        idle(DIV * 2 + 2);

        // Simultaneous mode and inc edges in SET_HR.
        press_mode();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        press_mode();
        idle(DIV * 2);

        // Reset mid-edit at 12:34 in SET_MIN.
        press_mode();
        while (m_t / 3600 != 12) press_inc();
        press_mode();
        while ((m_t / 60) % 60 != 34) press_inc();
        cyc(1'b0, 1'b0, 1'b1);
        idle(DIV * 3 + 1);

        // Random button levels with occasional reset.
        rb = 0;
        ri = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rb = ~rb;
            if ($urandom_range(5) == 0) ri = ~ri;
            cyc(rb, ri, ($urandom_range(299) == 0));
        end
        idle(4);

        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
